// File: rtl/instr_encode_loader.sv
// RV32I field-bundle encoder and instruction-memory program loader.
// Accepts decoded fields over valid/ready and writes encoded words to consecutive addresses.
module instr_encode_loader #(
    parameter int ADDR_W      = 10,
    parameter int BASE_ADDR   = 0,
    parameter int DEPTH_WORDS = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        op_class,
    input  logic [2:0]        funct3,
    input  logic              alt,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [31:0]       imm,
    input  logic              last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] count
);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FLUSH, S_DONE, S_ERR} state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    state_t            state_q, state_d;
    logic              we_q, we_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W-1:0] count_q, count_d;
    logic              err_q, err_d;
    logic              done_q, done_d;

    logic        xfer, start_ok, ovf, illegal, shift;
    logic        i_ok, b_ok, j_ok;
    logic [31:0] enc;

    // Encoder and legality check; enc is only meaningful when illegal is 0.
    always_comb begin
        enc     = 32'd0;
        illegal = 1'b0;
        shift   = (funct3 == 3'b001) || (funct3 == 3'b101);
        i_ok    = (&imm[31:11]) || ~(|imm[31:11]);
        b_ok    = (&imm[31:12]) || ~(|imm[31:12]);
        j_ok    = (&imm[31:20]) || ~(|imm[31:20]);
        case (op_class)
            4'd0: begin
                enc = {1'b0, alt, 5'b0, rs2, rs1, funct3, rd, OP_R};
                if (alt && funct3 != 3'b000 && funct3 != 3'b101) illegal = 1'b1;
            end
            4'd1: begin
                if (alt && funct3 != 3'b101) illegal = 1'b1;
                if (!i_ok) illegal = 1'b1;
                if (shift) begin
                    // imm[10] mirrors the alt bit and is taken from alt, so it is not checked
                    if (imm[11] || (|imm[9:5])) illegal = 1'b1;
                    enc = {1'b0, alt, 5'b0, imm[4:0], rs1, funct3, rd, OP_IALU};
                end else begin
                    enc = {imm[11:0], rs1, funct3, rd, OP_IALU};
                end
            end
            4'd2: begin
                enc = {imm[11:0], rs1, funct3, rd, OP_LOAD};
                if (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111) illegal = 1'b1;
                if (!i_ok) illegal = 1'b1;
            end
            4'd3: begin
                enc = {imm[11:5], rs2, rs1, funct3, imm[4:0], OP_STORE};
                if (funct3 > 3'b010 || !i_ok) illegal = 1'b1;
            end
            4'd4: begin
                enc = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OP_BRANCH};
                if (funct3 == 3'b010 || funct3 == 3'b011) illegal = 1'b1;
                if (imm[0] || !b_ok) illegal = 1'b1;
            end
            4'd5: begin
                enc = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
                if (imm[0] || !j_ok) illegal = 1'b1;
            end
            4'd6: begin
                enc = {imm[11:0], rs1, 3'b000, rd, OP_JALR};
                if (!i_ok) illegal = 1'b1;
            end
            4'd7: enc = {imm[31:12], rd, OP_LUI};
            4'd8: enc = {imm[31:12], rd, OP_AUIPC};
            default: illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            wdata_q <= 32'd0;
            ptr_q   <= ADDR_W'(BASE_ADDR);
            count_q <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        xfer     = in_valid && (state_q == S_LOAD);
        start_ok = start && (state_q == S_IDLE || state_q == S_DONE || state_q == S_ERR);
        // A write still in the pipeline counts against the session depth.
        ovf      = ({1'b0, count_q} + (ADDR_W + 1)'(we_q)) == (ADDR_W + 1)'(DEPTH_WORDS);
        state_d  = state_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERR: if (start_ok) state_d = S_LOAD;
            S_LOAD: begin
                if (xfer) begin
                    if (illegal || ovf) state_d = S_ERR;
                    else if (last)      state_d = S_FLUSH;
                end
            end
            S_FLUSH: state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        we_d    = xfer && !illegal && !ovf;
        wdata_d = we_d ? enc : wdata_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        err_d   = err_q;
        done_d  = (state_q == S_FLUSH);
        if (start_ok) begin
            ptr_d   = ADDR_W'(BASE_ADDR);
            count_d = '0;
            err_d   = 1'b0;
        end else if (we_q) begin
            ptr_d   = ptr_q + ADDR_W'(4);
            count_d = count_q + ADDR_W'(1);
        end
        if (xfer && (illegal || ovf)) err_d = 1'b1;
    end

    always_comb begin
        in_ready   = (state_q == S_LOAD);
        busy       = (state_q == S_LOAD) || (state_q == S_FLUSH);
        imem_we    = we_q;
        imem_addr  = ptr_q;
        imem_wdata = wdata_q;
        done       = done_q;
        err        = err_q;
        count      = count_q;
    end

endmodule

// File: doc/instr_encode_loader.md
Name: instr_encode_loader

Overview:
Sequential RV32I instruction encoder and program loader, the inverse of the CPU control/decode path. It accepts decoded instruction fields over a valid/ready handshake, assembles each into a 32-bit RV32I word and writes it into instruction memory at consecutive word addresses from a base. The testbench and boot path use it to build programs for the single-cycle core without precompiled hex files.

Parameters:
ADDR_W, 10, byte-address width of imem_addr.
BASE_ADDR, 0, byte address of the first word written after start; word aligned.
DEPTH_WORDS, 256, maximum words per load session.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  begin a load session at BASE_ADDR; honoured only in IDLE, DONE or ERR.
in_valid  input  1  field bundle valid.
in_ready  output  1  block can accept a bundle this cycle.
op_class  input  4  0=R, 1=I-ALU, 2=LOAD, 3=STORE, 4=BRANCH, 5=JAL, 6=JALR, 7=LUI, 8=AUIPC; 9-15 illegal.
funct3  input  3  funct3 field.
alt  input  1  instruction bit 30 (sub/sra/srai select).
rd, rs1, rs2  input  5 each  register indices.
imm  input  32  immediate. LUI/AUIPC use imm[31:12]. Other classes use the signed value.
last  input  1  bundle is the final instruction of the session.
imem_we  output  1  one-cycle instruction-memory write strobe.
imem_addr  output  ADDR_W  byte address of the write.
imem_wdata  output  32  encoded instruction.
busy  output  1  session in progress.
done  output  1  one-cycle pulse after the last write.
err  output  1  sticky illegal-input or overflow flag.
count  output  ADDR_W  words written in the current session.

Behaviour:
- Reset: state IDLE. in_ready, imem_we, busy, done and err are 0. imem_addr is BASE_ADDR. imem_wdata and count are 0. Reset mid-session aborts it, and no write occurs on or after the reset edge.
- States are IDLE, LOAD, FLUSH, DONE and ERR.
  - IDLE/DONE/ERR + start -> LOAD: clear err and count, set the address pointer to BASE_ADDR.
  - start while in LOAD or FLUSH is ignored.
- Handshake:
  - in_ready = (state==LOAD).
  - A transfer occurs when in_valid && in_ready. in_valid may stay high across cycles; each cycle with both high is a new transfer.
- Pipeline: a transfer at edge N registers the encoded word. imem_we is high for exactly the cycle after edge N, with imem_addr equal to the pointer and imem_wdata equal to the word. The pointer advances by 4 and count by 1 on the following edge. Throughput is 1 word per cycle.
- Opcodes: R 0110011, I-ALU 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111.
- Field placement: rd[11:7], funct3[14:12], rs1[19:15], rs2[24:20].
- Formats:
  - R: bit30 = alt, other funct7 bits 0.
  - I: imm[11:0] into [31:20].
  - I-ALU shifts (funct3 001/101): [31:25] = {0, alt, 00000}, [24:20] = imm[4:0].
  - S and B: standard RV32I scatter.
  - U: imm[31:12] into [31:12].
  - J: standard RV32I scatter.
  - JALR: funct3 forced to 000.
  - Fields unused by a format are 0.
- Illegal bundle: the bundle is consumed, nothing is written, err is set and the state goes to ERR. Illegal means any of:
  - op_class above 8.
  - R with alt=1 and funct3 not 000/101.
  - I-ALU with alt=1 and funct3 not 101, or a shift with imm[11:5] nonzero except the alt bit.
  - LOAD funct3 not in {000,001,010,100,101}.
  - STORE funct3 above 010.
  - BRANCH funct3 of 010 or 011.
  - BRANCH/JAL imm[0]=1.
  - Signed immediate out of range for its format.
- Overflow: a transfer when count plus pending writes equals DEPTH_WORDS sets err, writes nothing and goes to ERR. The address never wraps.
- last: once the last word is accepted, in_ready drops and the state goes to FLUSH. FLUSH completes the write, then moves to DONE with done pulsed for 1 cycle. DONE behaves as idle and keeps count.
- busy = (state==LOAD or FLUSH).

Test Plan:
- Reset, start, then addi x1,x0,5 with last -> imem_we at 0x000 with 0x00500093; done pulses; count=1.
- Back-to-back at 1/cycle: add x3,x1,x2; sub x3,x1,x2; srai x4,x1,3 -> writes 0x002081B3 @0x000, 0x402081B3 @0x004, 0x4030D213 @0x008 on consecutive cycles.
- Store and branch: sw x2,8(x1) -> 0x0020A423. beq x1,x2,+8 -> 0x00208463. jal x1,+16 -> 0x010000EF. lui x5,imm=0x12345000 -> 0x123452B7.
- Illegal inputs: op_class=9 -> no imem_we, err=1, in_ready=0. A new start clears err and resumes at BASE_ADDR.
- Overflow with DEPTH_WORDS=4: a 5th bundle -> exactly 4 writes (0x000-0x00C), then err=1.
- Reset asserted during a session with in_valid held high -> no imem_we after the reset edge; outputs return to their reset values.
